// File: rtl/prbs_err_monitor.sv
// prbs_err_monitor
// Per-lane PRBS error accumulator placed after the PRBS checkers.
// Each lane has a lock FSM, a saturating error counter and an LED blanking
// timer. A lane-select mux presents one lane's count on err_count.
//
// Lane FSM states:
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   ST_SEARCH | hunting for LOCK_CYCLES consecutive clean cycles; errors ignored
//   ST_LOCKED | lane aligned; errors counted, BAD_LIMIT consecutive errors unlock
//
// All lanes are independent. Every output is registered except lock and
// err_sat, which decode lane registers directly.

module prbs_err_monitor #(
    parameter int NCH         = 8,
    parameter int CNT_W       = 32,
    parameter int LOCK_CYCLES = 1024,
    parameter int BAD_LIMIT   = 16,
    parameter int STRETCH     = 4000000
) (
    input  logic                     txusrclk2,
    input  logic                     reset,
    input  logic [NCH-1:0]           prbs_error,
    input  logic                     PRBS_counter_reset_user,
    input  logic [$clog2(NCH)-1:0]   ch_sel,
    output logic [CNT_W-1:0]         err_count,
    output logic [NCH-1:0]           err_sat,
    output logic [NCH-1:0]           lock,
    output logic                     err_any,
    output logic [NCH-1:0]           led_fp
);

    localparam int CLEAN_W = $clog2(LOCK_CYCLES + 1);
    localparam int BAD_W   = $clog2(BAD_LIMIT + 1);
    localparam int STR_W   = $clog2(STRETCH + 1);

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } lane_state_e;

    lane_state_e         state_q [NCH];
    lane_state_e         state_d [NCH];
    logic [CLEAN_W-1:0]  clean_q [NCH];
    logic [CLEAN_W-1:0]  clean_d [NCH];
    logic [BAD_W-1:0]    bad_q   [NCH];
    logic [BAD_W-1:0]    bad_d   [NCH];
    logic [CNT_W-1:0]    cnt_q   [NCH];
    logic [CNT_W-1:0]    cnt_d   [NCH];
    logic [STR_W-1:0]    str_q   [NCH];
    logic [STR_W-1:0]    str_d   [NCH];
    logic [NCH-1:0]      led_q;
    logic [NCH-1:0]      led_d;
    logic [CNT_W-1:0]    err_count_q;
    logic [CNT_W-1:0]    err_count_d;
    logic                err_any_q;
    logic                err_any_d;

    // Per-lane next state: lock FSM, run counters, saturating count, blanking timer.
    // The LED is derived from next-state values so it drops on the same edge lock drops.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            clean_d[i] = clean_q[i];
            bad_d[i]   = bad_q[i];
            cnt_d[i]   = cnt_q[i];
            str_d[i]   = (str_q[i] != '0) ? (str_q[i] - STR_W'(1)) : '0;

            case (state_q[i])
                ST_SEARCH: begin
                    if (prbs_error[i]) begin
                        clean_d[i] = '0;
                    end else if (clean_q[i] == CLEAN_W'(LOCK_CYCLES - 1)) begin
                        state_d[i] = ST_LOCKED;
                        clean_d[i] = '0;
                        bad_d[i]   = '0;
                    end else begin
                        clean_d[i] = clean_q[i] + CLEAN_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (prbs_error[i]) begin
                        if (cnt_q[i] != '1) begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                        str_d[i] = STR_W'(STRETCH);
                        if (bad_q[i] == BAD_W'(BAD_LIMIT - 1)) begin
                            state_d[i] = ST_SEARCH;
                            bad_d[i]   = '0;
                            clean_d[i] = '0;
                        end else begin
                            bad_d[i] = bad_q[i] + BAD_W'(1);
                        end
                    end else begin
                        bad_d[i] = '0;
                    end
                end
                default: begin
                    state_d[i] = ST_SEARCH;
                end
            endcase

            // User clear beats a same-cycle error; lock tracking is left alone.
            if (PRBS_counter_reset_user) begin
                cnt_d[i] = '0;
                str_d[i] = '0;
            end

            led_d[i] = (state_d[i] == ST_LOCKED) && (str_d[i] == '0);
        end
    end

    // Lane-select mux and locked-lane error OR feeding the registered debug outputs.
    always_comb begin
        err_count_d = '0;
        if (int'(ch_sel) < NCH) begin
            err_count_d = cnt_q[ch_sel];
        end
        err_any_d = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            err_any_d = err_any_d | (prbs_error[i] & (state_q[i] == ST_LOCKED));
        end
    end

    // State and output registers with synchronous reset that overrides all inputs.
    always_ff @(posedge txusrclk2) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= ST_SEARCH;
                clean_q[i] <= '0;
                bad_q[i]   <= '0;
                cnt_q[i]   <= '0;
                str_q[i]   <= '0;
            end
            led_q       <= '0;
            err_count_q <= '0;
            err_any_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                clean_q[i] <= clean_d[i];
                bad_q[i]   <= bad_d[i];
                cnt_q[i]   <= cnt_d[i];
                str_q[i]   <= str_d[i];
            end
            led_q       <= led_d;
            err_count_q <= err_count_d;
            err_any_q   <= err_any_d;
        end
    end

    // Direct decodes of lane registers for lock and saturation flags.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            lock[i]    = (state_q[i] == ST_LOCKED);
            err_sat[i] = (cnt_q[i] == '1);
        end
    end

    assign err_count = err_count_q;
    assign err_any   = err_any_q;
    assign led_fp    = led_q;

endmodule

// File: tb/tb_prbs_err_monitor.sv
// Directed bench for prbs_err_monitor with shortened timing parameters:
// LOCK_CYCLES=16, BAD_LIMIT=4, STRETCH=8, CNT_W=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too,
// so each check sees the result of the edge just taken.

module tb_prbs_err_monitor;

    localparam int NCH = 8;
    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic [NCH-1:0]   prbs_error;
    logic             clr_user;
    logic [2:0]       ch_sel;
    logic [CNT_W-1:0] err_count;
    logic [NCH-1:0]   err_sat;
    logic [NCH-1:0]   lock;
    logic             err_any;
    logic [NCH-1:0]   led_fp;

    int checks = 0;
    int errors = 0;

    prbs_err_monitor #(
        .NCH(NCH), .CNT_W(CNT_W), .LOCK_CYCLES(16), .BAD_LIMIT(4), .STRETCH(8)
    ) dut (
        .txusrclk2(clk),
        .reset(reset),
        .prbs_error(prbs_error),
        .PRBS_counter_reset_user(clr_user),
        .ch_sel(ch_sel),
        .err_count(err_count),
        .err_sat(err_sat),
        .lock(lock),
        .err_any(err_any),
        .led_fp(led_fp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; prbs_error = 8'hFF; clr_user = 1'b0; ch_sel = 3'd0;
        tick();
        tick();
        checks++; if (lock !== 8'h00) begin errors++; $display("FAIL reset_lock: got %h expected 00", lock); end
        checks++; if (led_fp !== 8'h00) begin errors++; $display("FAIL reset_led: got %h expected 00", led_fp); end
        checks++; if (err_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", err_count); end
        checks++; if (err_any !== 1'b0) begin errors++; $display("FAIL reset_err_any: got %b expected 0", err_any); end
        checks++; if (err_sat !== 8'h00) begin errors++; $display("FAIL reset_sat: got %h expected 00", err_sat); end
    endtask

    task automatic test_lock_all();
        reset = 1'b0; prbs_error = 8'h00;
        for (int k = 0; k < 15; k++) tick();
        checks++; if (lock !== 8'h00) begin errors++; $display("FAIL lock_early: got %h expected 00 after 15 clean", lock); end
        tick();
        checks++; if (lock !== 8'hFF) begin errors++; $display("FAIL lock_16: got %h expected FF", lock); end
        checks++; if (led_fp !== 8'hFF) begin errors++; $display("FAIL led_after_lock: got %h expected FF", led_fp); end
        checks++; if (err_count !== 4'd0) begin errors++; $display("FAIL count_after_lock: got %0d expected 0", err_count); end
    endtask

    task automatic test_single_error();
        int dark;
        ch_sel = 3'd3;
        prbs_error = 8'h08;
        tick();
        checks++; if (lock !== 8'hFF) begin errors++; $display("FAIL single_lock: got %h expected FF", lock); end
        checks++; if (led_fp !== 8'hF7) begin errors++; $display("FAIL single_led: got %h expected F7", led_fp); end
        checks++; if (err_any !== 1'b1) begin errors++; $display("FAIL single_err_any: got %b expected 1", err_any); end
        checks++; if (err_count !== 4'd0) begin errors++; $display("FAIL single_latency: got %0d expected 0 one cycle after", err_count); end
        prbs_error = 8'h00;
        tick();
        checks++; if (err_count !== 4'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", err_count); end
        checks++; if (err_any !== 1'b0) begin errors++; $display("FAIL single_err_any_clr: got %b expected 0", err_any); end
        dark = 2;
        for (int k = 0; k < 6; k++) begin
            if (led_fp[3] === 1'b0) dark++;
            tick();
        end
        if (led_fp[3] === 1'b0) dark++;
        checks++; if (dark !== 9) begin errors++; $display("FAIL single_stretch: got %0d dark samples expected 8", dark - 1); end
        tick();
        checks++; if (led_fp !== 8'hFF) begin errors++; $display("FAIL single_led_back: got %h expected FF", led_fp); end
        checks++; if (lock !== 8'hFF) begin errors++; $display("FAIL single_lock_end: got %h expected FF", lock); end
    endtask

    task automatic test_loss_of_lock();
        ch_sel = 3'd5;
        prbs_error = 8'h20;
        for (int k = 0; k < 3; k++) tick();
        checks++; if (lock[5] !== 1'b1) begin errors++; $display("FAIL lol_hold3: got %b expected 1", lock[5]); end
        tick();
        checks++; if (lock !== 8'hDF) begin errors++; $display("FAIL lol_drop: got %h expected DF", lock); end
        checks++; if (led_fp !== 8'hDF) begin errors++; $display("FAIL lol_led: got %h expected DF", led_fp); end
        checks++; if (err_any !== 1'b1) begin errors++; $display("FAIL lol_err_any: got %b expected 1", err_any); end
        prbs_error = 8'h00;
        tick();
        checks++; if (err_count !== 4'd4) begin errors++; $display("FAIL lol_count: got %0d expected 4", err_count); end
        for (int k = 0; k < 14; k++) tick();
        checks++; if (lock[5] !== 1'b0) begin errors++; $display("FAIL relock_early: got %b expected 0", lock[5]); end
        tick();
        checks++; if (lock !== 8'hFF) begin errors++; $display("FAIL relock: got %h expected FF", lock); end
        checks++; if (led_fp !== 8'hFF) begin errors++; $display("FAIL relock_led: got %h expected FF", led_fp); end
        checks++; if (err_count !== 4'd4) begin errors++; $display("FAIL relock_count: got %0d expected 4", err_count); end
    endtask

    task automatic test_ch_sel();
        ch_sel = 3'd3;
        tick();
        checks++; if (err_count !== 4'd1) begin errors++; $display("FAIL chsel_3: got %0d expected 1", err_count); end
        ch_sel = 3'd0;
        tick();
        checks++; if (err_count !== 4'd0) begin errors++; $display("FAIL chsel_0: got %0d expected 0", err_count); end
        ch_sel = 3'd5;
        tick();
        checks++; if (err_count !== 4'd4) begin errors++; $display("FAIL chsel_5: got %0d expected 4", err_count); end
    endtask

    task automatic test_saturation();
        ch_sel = 3'd0;
        for (int k = 0; k < 20; k++) begin
            prbs_error = 8'h01;
            tick();
            prbs_error = 8'h00;
            tick();
            if (k == 13) begin
                checks++; if (err_count !== 4'd14) begin errors++; $display("FAIL sat_ramp: got %0d expected 14", err_count); end
                checks++; if (err_sat !== 8'h00) begin errors++; $display("FAIL sat_early: got %h expected 00", err_sat); end
            end
        end
        checks++; if (err_count !== 4'd15) begin errors++; $display("FAIL sat_count: got %0d expected 15", err_count); end
        checks++; if (err_sat !== 8'h01) begin errors++; $display("FAIL sat_flag: got %h expected 01", err_sat); end
        checks++; if (lock !== 8'hFF) begin errors++; $display("FAIL sat_lock: got %h expected FF", lock); end
        prbs_error = 8'h01; clr_user = 1'b1;
        tick();
        checks++; if (err_sat !== 8'h00) begin errors++; $display("FAIL clr_sat: got %h expected 00", err_sat); end
        checks++; if (lock !== 8'hFF) begin errors++; $display("FAIL clr_lock: got %h expected FF", lock); end
        checks++; if (led_fp !== 8'hFF) begin errors++; $display("FAIL clr_led: got %h expected FF", led_fp); end
        prbs_error = 8'h00; clr_user = 1'b0;
        tick();
        checks++; if (err_count !== 4'd0) begin errors++; $display("FAIL clr_count: got %0d expected 0", err_count); end
        ch_sel = 3'd5;
        tick();
        checks++; if (err_count !== 4'd0) begin errors++; $display("FAIL clr_other_lane: got %0d expected 0", err_count); end
    endtask

    task automatic test_search_errors();
        int bad_any;
        int bad_lock;
        ch_sel = 3'd7;
        prbs_error = 8'h80;
        for (int k = 0; k < 4; k++) tick();
        checks++; if (lock !== 8'h7F) begin errors++; $display("FAIL search_unlock: got %h expected 7F", lock); end
        prbs_error = 8'h00; clr_user = 1'b1;
        tick();
        clr_user = 1'b0;
        bad_any = 0; bad_lock = 0;
        for (int k = 0; k < 30; k++) begin
            prbs_error = (k % 3 == 0) ? 8'h80 : 8'h00;
            tick();
            if (err_any !== 1'b0) bad_any++;
            if (lock[7] !== 1'b0) bad_lock++;
        end
        checks++; if (bad_any !== 0) begin errors++; $display("FAIL search_err_any: got %0d high samples expected 0", bad_any); end
        checks++; if (bad_lock !== 0) begin errors++; $display("FAIL search_lock: got %0d locked samples expected 0", bad_lock); end
        prbs_error = 8'h00;
        tick();
        checks++; if (err_count !== 4'd0) begin errors++; $display("FAIL search_count: got %0d expected 0", err_count); end
        checks++; if (led_fp !== 8'h7F) begin errors++; $display("FAIL search_led: got %h expected 7F", led_fp); end
    endtask

    task automatic test_reset_mid_locked();
        ch_sel = 3'd0;
        prbs_error = 8'h01;
        tick();
        prbs_error = 8'h00;
        tick();
        checks++; if (err_count !== 4'd1) begin errors++; $display("FAIL mid_pre_count: got %0d expected 1", err_count); end
        reset = 1'b1; prbs_error = 8'h01; clr_user = 1'b0;
        tick();
        checks++; if (lock !== 8'h00) begin errors++; $display("FAIL mid_lock: got %h expected 00", lock); end
        checks++; if (led_fp !== 8'h00) begin errors++; $display("FAIL mid_led: got %h expected 00", led_fp); end
        checks++; if (err_count !== 4'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", err_count); end
        checks++; if (err_any !== 1'b0) begin errors++; $display("FAIL mid_err_any: got %b expected 0", err_any); end
        reset = 1'b0; prbs_error = 8'h00;
        for (int k = 0; k < 15; k++) tick();
        checks++; if (lock !== 8'h00) begin errors++; $display("FAIL mid_relock_early: got %h expected 00", lock); end
        tick();
        checks++; if (lock !== 8'hFF) begin errors++; $display("FAIL mid_relock: got %h expected FF", lock); end
        checks++; if (err_count !== 4'd0) begin errors++; $display("FAIL mid_relock_count: got %0d expected 0", err_count); end
    endtask

    initial begin
        reset = 1'b1; prbs_error = '0; clr_user = 1'b0; ch_sel = '0;
        test_reset();
        test_lock_all();
        test_single_error();
        test_loss_of_lock();
        test_ch_sel();
        test_saturation();
        test_search_errors();
        test_reset_mid_locked();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
